// File: rtl/seq_slice_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock and ripples the carry
// between slices through a carry register, so no full-width carry chain exists.
`timescale 1ns/1ps

module seq_slice_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SW     = CHUNK + 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  generate
    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("seq_slice_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] s;
  logic             c;
  logic             accept;
  logic             release_out;
  logic             last;

  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last        = (cnt_q == LAST);

  // Slice adder for the slice currently addressed by the counter.
  always_comb begin
    base  = 32'(cnt_q) * 32'(CHUNK);
    a_sl  = a_q[base +: CHUNK];
    b_sl  = b_q[base +: CHUNK];
    {c, s} = {1'b0, a_sl} + {1'b0, b_sl} + SW'(carry_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
  end

  // Subtraction is a + ~b + ~cin, so the operand inversion and borrow-to-carry
  // conversion happen once at accept time and RUN is a plain adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[base +: CHUNK] <= s;
          carry_q              <= c;
          if (last) begin
            cout_q <= c;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s[CHUNK-1] != a_q[WIDTH-1]);
            cnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_slice_adder.sv
// Directed and table-driven checks of seq_slice_adder (32/8), plus a random
// sweep against a signed-integer reference at 16/1 and 16/16.
`timescale 1ns/1ps

module tb_seq_slice_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, busy;
  logic [31:0] a, b, sum;

  logic [1:0]  s_in_valid, s_in_ready, s_cin, s_sub, s_out_valid, s_out_ready;
  logic [1:0]  s_cout, s_ovf, s_busy;
  logic [15:0] s_a [2];
  logic [15:0] s_b [2];
  logic [15:0] s_sum [2];

  int checks = 0;
  int errors = 0;

  seq_slice_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
  );

  seq_slice_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
    .a(s_a[0]), .b(s_b[0]), .cin(s_cin[0]), .sub(s_sub[0]), .out_valid(s_out_valid[0]),
    .out_ready(s_out_ready[0]), .sum(s_sum[0]), .cout(s_cout[0]), .overflow(s_ovf[0]),
    .busy(s_busy[0])
  );

  seq_slice_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
    .a(s_a[1]), .b(s_b[1]), .cin(s_cin[1]), .sub(s_sub[1]), .out_valid(s_out_valid[1]),
    .out_ready(s_out_ready[1]), .sum(s_sum[1]), .cout(s_cout[1]), .overflow(s_ovf[1]),
    .busy(s_busy[1])
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic vcin, input logic vsub, input logic [31:0] esum,
                       input logic ecout, input logic eovf);
    int lat;
    chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the operation in flight must not see them.
    a = ~va; b = ~vb; cin = ~vcin; sub = ~vsub;
    chk({tag, " busy/in_ready/out_valid"}, {29'd0, busy, in_ready, out_valid}, 32'b100);
    wait_out(lat);
    chk({tag, " latency"}, 32'(lat), 32'd4);
    chk({tag, " sum"}, sum, esum);
    chk({tag, " cout/overflow"}, {30'd0, cout, overflow}, {30'd0, ecout, eovf});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post-handshake out_valid/in_ready/busy"},
        {29'd0, out_valid, in_ready, busy}, 32'b010);
  endtask

  task automatic sweep_op(input int i, input int exp_lat);
    logic [15:0] va, vb;
    logic        vcin, vsub;
    int          ia, ib, ir, ur;
    logic [15:0] esum;
    logic        ecout, eovf;
    int          lat;
    va = 16'($urandom); vb = 16'($urandom);
    vcin = 1'($urandom); vsub = 1'($urandom);
    ia = int'($signed(va)); ib = int'($signed(vb));
    ir = vsub ? ia - ib - int'(vcin) : ia + ib + int'(vcin);
    ur = vsub ? int'(va) - int'(vb) - int'(vcin) : int'(va) + int'(vb) + int'(vcin);
    esum  = 16'(ur);
    ecout = vsub ? (ur >= 0) : (ur > 65535);
    eovf  = (ir > 32767) || (ir < -32768);
    s_a[i] = va; s_b[i] = vb; s_cin[i] = vcin; s_sub[i] = vsub; s_in_valid[i] = 1'b1;
    @(posedge clk); #1;
    s_in_valid[i] = 1'b0;
    s_a[i] = ~va; s_b[i] = ~vb; s_cin[i] = ~vcin; s_sub[i] = ~vsub;
    lat = 0;
    while (!s_out_valid[i] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("sweep%0d latency", i), 32'(lat), 32'(exp_lat));
    chk($sformatf("sweep%0d a=%h b=%h cin=%b sub=%b {cout,ovf,sum}", i, va, vb, vcin, vsub),
        {14'd0, s_cout[i], s_ovf[i], s_sum[i]}, {14'd0, ecout, eovf, esum});
    s_out_ready[i] = 1'b1;
    @(posedge clk); #1;
    s_out_ready[i] = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] hold_sum;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[2] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0100_0001, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
    vecs[7] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = '0; s_out_ready = '0; s_cin = '0; s_sub = '0;
    s_a[0] = '0; s_a[1] = '0; s_b[0] = '0; s_b[1] = '0;
    #1;
    chk("reset sum", sum, 32'h0);
    chk("reset cout/ovf/out_valid/busy/in_ready",
        {27'd0, cout, overflow, out_valid, busy, in_ready}, 32'b00001);
    chk("reset sweep in_ready/out_valid", {28'd0, s_in_ready, s_out_valid}, 32'b1100);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // Back-pressure: result must hold and in_valid pulses must be ignored.
    a = 32'h7FFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("hold latency", 32'(lat), 32'd4);
    hold_sum = sum;
    chk("hold sum", hold_sum, 32'h8000_0000);
    for (int k = 0; k < 3; k++) begin
      a = 32'h5; b = 32'h5; in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("hold cyc%0d sum", k), sum, 32'h8000_0000);
      chk($sformatf("hold cyc%0d cout/ovf/out_valid/in_ready", k),
          {28'd0, cout, overflow, out_valid, in_ready}, 32'b0110);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold release in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen++;
    end
    chk("hold ignored pulses", 32'(seen), 32'd0);

    // Reset two cycles after accept aborts the operation immediately.
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-op reset sum", sum, 32'h0);
    chk("mid-op reset out_valid/in_ready/busy/cout/ovf",
        {27'd0, out_valid, in_ready, busy, cout, overflow}, 32'b01000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("no stale out_valid", 32'(seen), 32'd0);
    do_op("after reset 3+4", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) sweep_op(0, 16);
    for (int n = 0; n < 1000; n++) sweep_op(1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_slice_adder.md
Name: seq_slice_adder

Overview:
Parametrised multi-cycle adder/subtractor. It adds or subtracts WIDTH-bit operands CHUNK bits per clock, rippling the carry between slices through a carry register. It generalises the team's 16-bit ripple adder to arbitrary width with a subtract mode, signed overflow detection and valid/ready handshakes. It is used where a full-width combinational carry chain would miss timing.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per clock; 1 <= CHUNK <= WIDTH.
NSLICE (derived, localparam), WIDTH/CHUNK, number of slice cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand set valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (borrow-in when sub=1).
sub  input  1  0: a+b+cin; 1: a-b-cin.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
sum  output  WIDTH  result.
cout  output  1  carry-out of MSB (sub mode: 1 = no borrow).
overflow  output  1  two's-complement signed overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, slice counter=0, carry reg=0, operand/result regs=0. Outputs during and after reset: sum=0, cout=0, overflow=0, out_valid=0, busy=0, in_ready=1.
- FSM states: IDLE, RUN, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. busy = (RUN or DONE).
- IDLE: when in_valid && in_ready at a rising edge:
  - latch a;
  - latch b_eff = sub ? ~b : b;
  - carry reg <= sub ? ~cin : cin;
  - latch sub;
  - counter <= 0;
  - go to RUN.
  - Inputs are ignored when no handshake occurs.
- RUN: each cycle, slice k = counter computes {c, s} = a[k*CHUNK +: CHUNK] + b_eff[k*CHUNK +: CHUNK] + carry.
  - sum reg slice k <= s; carry reg <= c; counter++.
  - On the slice with k = NSLICE-1: cout <= c; overflow <= (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]); go to DONE.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge. Defaults: 4 cycles.
- DONE: sum, cout and overflow are held stable while out_valid=1 && out_ready=0. When out_valid && out_ready at an edge, go to IDLE and drop out_valid.
  - No same-cycle re-accept; in_ready rises the cycle after the output handshake.
  - Throughput: one operation per NSLICE+2 cycles minimum.
- Arithmetic is modulo 2^WIDTH. Sub mode result is a - b - cin. Only the full WIDTH-bit result is valid; partial sum bits are not observable as valid.
- Changes on a, b, cin or sub after acceptance have no effect on the operation in flight.
- Reset asserted mid-operation (RUN or DONE) aborts it immediately. All outputs go to reset values and no stale out_valid appears after reset release.
- NSLICE=1 (CHUNK=WIDTH): RUN lasts one cycle, latency 1.
- Illegal parameters (WIDTH % CHUNK != 0) fail elaboration with a generate-time error.

Test Plan:
- Defaults, a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, overflow=0; out_valid exactly 4 cycles after the accept edge.
- Inter-slice carry, a=0x000000FF, b=0x00000001 -> sum=0x00000100, cout=0. Also a=0x00FFFFFF, b=1, cin=1 -> sum=0x01000001.
- Subtract, a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0 (borrow), overflow=0. Also a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, overflow=1.
- Add overflow, a=0x7FFFFFFF, b=1 -> sum=0x80000000, overflow=1, cout=0. Hold out_ready=0 for 3 cycles -> sum/cout/overflow stable, out_valid=1, in_ready=0; in_valid pulses in that window are ignored.
- Reset in flight: assert rst_n=0 two cycles after accept -> out_valid=0, sum=0, in_ready=1 immediately. After release, a new op 3+4 -> sum=7, with no stale result.
- Parameter sweep WIDTH=16, CHUNK=1 (latency 16) and WIDTH=16, CHUNK=16 (latency 1), 1000 random a/b/cin/sub each -> match reference model bit-exactly, including cout and overflow.
